// File: rtl/mem_ctrl_pkg.sv
// Shared definitions for the memory arbiter: FSM state encoding and the
// default cache-block size in 16-bit words.
package mem_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FILL  = 2'd1,
        WRITE = 2'd2,
        DONE  = 2'd3
    } arb_state_t;

    localparam int unsigned WORDS_PER_BLOCK_DEF = 8;

endpackage

// File: rtl/block_fill_counter.sv
// Issue and return word counters for a block fill. Both wrap at
// WORDS_PER_BLOCK and are cleared when a fill starts.
// Ports: clk, rst (async, active high), clear, issue/ret increments,
//        issue_cnt/ret_cnt counts, issue_last/ret_last at final word.
module block_fill_counter #(
    parameter int unsigned WORDS_PER_BLOCK = 8,
    parameter int unsigned CW = $clog2(WORDS_PER_BLOCK)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          clear,
    input  logic          issue,
    input  logic          ret,
    output logic [CW-1:0] issue_cnt,
    output logic [CW-1:0] ret_cnt,
    output logic          issue_last,
    output logic          ret_last
);

    localparam logic [CW-1:0] LAST = CW'(WORDS_PER_BLOCK - 1);

    assign issue_last = (issue_cnt == LAST);
    assign ret_last   = (ret_cnt == LAST);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            issue_cnt <= '0;
            ret_cnt   <= '0;
        end else if (clear) begin
            issue_cnt <= '0;
            ret_cnt   <= '0;
        end else begin
            if (issue)
                issue_cnt <= issue_last ? '0 : issue_cnt + 1'b1;
            if (ret)
                ret_cnt <= ret_last ? '0 : ret_cnt + 1'b1;
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Arbiter sharing one pipelined 16-bit memory between I-side block fills and
// D-side fills / single-word write-throughs.
// Ports: i_req/i_addr, d_req/d_wr/d_addr/d_wdata requests; mem_* memory bus;
//        fill_* returned words; grants, done pulses and busy status.
// Config: define MEM_ARB_ROUND_ROBIN_EN for round-robin arbitration on
//         simultaneous requests; otherwise the D-side has fixed priority.
module mem_arbiter
    import mem_ctrl_pkg::*;
#(
    parameter int unsigned WORDS_PER_BLOCK = WORDS_PER_BLOCK_DEF,
    parameter int unsigned ADDR_W = 16,
    parameter int unsigned CW = $clog2(WORDS_PER_BLOCK)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_req,
    input  logic [ADDR_W-1:0] i_addr,
    input  logic              d_req,
    input  logic              d_wr,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [15:0]       d_wdata,
    output logic              mem_en,
    output logic              mem_wr,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [15:0]       mem_wdata,
    input  logic [15:0]       mem_rdata,
    input  logic              mem_valid,
    output logic [15:0]       fill_data,
    output logic              fill_valid,
    output logic [CW-1:0]     fill_word,
    output logic              i_grant,
    output logic              d_grant,
    output logic              i_done,
    output logic              d_done,
    output logic              busy
);

    // Clears the byte offset within a block of 16-bit words.
    localparam logic [ADDR_W-1:0] BASE_MASK =
        ~(ADDR_W'(2 * WORDS_PER_BLOCK - 1));

    arb_state_t state;
    logic       owner_d;
    logic       any_req;
    logic       d_first;
    logic       pick_d;
    logic       start_fill;
    logic       issue_inc;
    logic       ret_inc;
    logic [CW-1:0] issue_cnt;
    logic [CW-1:0] ret_cnt;
    logic       issue_last;
    logic       ret_last;

    assign any_req = i_req | d_req;
    assign pick_d  = d_req & (~i_req | d_first);

`ifdef MEM_ARB_ROUND_ROBIN_EN
    // Remembers who won the last grant; reset value makes D win first.
    logic last_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            last_d <= 1'b0;
        else if (state == IDLE && any_req)
            last_d <= pick_d;
    end

    assign d_first = ~last_d;
`else
    assign d_first = 1'b1;
`endif

    assign start_fill = (state == IDLE) & any_req & ~(pick_d & d_wr);
    assign issue_inc  = (state == FILL) & mem_en;
    assign ret_inc    = (state == FILL) & mem_valid;

    block_fill_counter #(
        .WORDS_PER_BLOCK(WORDS_PER_BLOCK),
        .CW             (CW)
    ) u_cnt (
        .clk       (clk),
        .rst       (rst),
        .clear     (start_fill),
        .issue     (issue_inc),
        .ret       (ret_inc),
        .issue_cnt (issue_cnt),
        .ret_cnt   (ret_cnt),
        .issue_last(issue_last),
        .ret_last  (ret_last)
    );

    // Returned words pass straight through in the cycle they arrive.
    assign fill_valid = ret_inc;
    assign fill_data  = ret_inc ? mem_rdata : 16'h0000;
    assign fill_word  = ret_inc ? ret_cnt : '0;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            owner_d   <= 1'b0;
            mem_en    <= 1'b0;
            mem_wr    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= 16'h0000;
            i_grant   <= 1'b0;
            d_grant   <= 1'b0;
            i_done    <= 1'b0;
            d_done    <= 1'b0;
            busy      <= 1'b0;
        end else begin
            i_done <= 1'b0;
            d_done <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (any_req) begin
                        owner_d <= pick_d;
                        i_grant <= ~pick_d;
                        d_grant <= pick_d;
                        busy    <= 1'b1;
                        mem_en  <= 1'b1;
                        if (pick_d && d_wr) begin
                            state     <= WRITE;
                            mem_wr    <= 1'b1;
                            mem_addr  <= d_addr;
                            mem_wdata <= d_wdata;
                        end else begin
                            state    <= FILL;
                            mem_addr <= (pick_d ? d_addr : i_addr) & BASE_MASK;
                        end
                    end
                end
                FILL: begin
                    if (mem_en) begin
                        if (issue_last) begin
                            mem_en   <= 1'b0;
                            mem_addr <= '0;
                        end else begin
                            mem_addr <= mem_addr + ADDR_W'(2);
                        end
                    end
                    if (mem_valid && ret_last) begin
                        state   <= DONE;
                        i_grant <= 1'b0;
                        d_grant <= 1'b0;
                        i_done  <= ~owner_d;
                        d_done  <= owner_d;
                    end
                end
                WRITE: begin
                    state     <= DONE;
                    mem_en    <= 1'b0;
                    mem_wr    <= 1'b0;
                    mem_addr  <= '0;
                    mem_wdata <= 16'h0000;
                    d_grant   <= 1'b0;
                    d_done    <= 1'b1;
                end
                DONE: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter with a 2-stage pipelined memory model
// and queue-based scoreboard.
module tb_mem_arbiter;

    localparam int WPB = 8;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        i_req = 1'b0;
    logic [15:0] i_addr = '0;
    logic        d_req = 1'b0;
    logic        d_wr = 1'b0;
    logic [15:0] d_addr = '0;
    logic [15:0] d_wdata = '0;
    logic        mem_en, mem_wr;
    logic [15:0] mem_addr, mem_wdata;
    logic [15:0] mem_rdata = '0;
    logic        mem_valid = 1'b0;
    logic [15:0] fill_data;
    logic        fill_valid;
    logic [2:0]  fill_word;
    logic        i_grant, d_grant, i_done, d_done, busy;

    mem_arbiter dut (
        .clk(clk), .rst(rst),
        .i_req(i_req), .i_addr(i_addr),
        .d_req(d_req), .d_wr(d_wr), .d_addr(d_addr), .d_wdata(d_wdata),
        .mem_en(mem_en), .mem_wr(mem_wr), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_valid(mem_valid),
        .fill_data(fill_data), .fill_valid(fill_valid), .fill_word(fill_word),
        .i_grant(i_grant), .d_grant(d_grant),
        .i_done(i_done), .d_done(d_done), .busy(busy)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;
    int prev_iss = 0;
    int last_end = 0;
    int fv_seen  = 0;

    typedef struct { logic [15:0] addr; int idx; bit d; } iss_t;
    typedef struct { logic [15:0] data; int idx; } fil_t;
    typedef struct { logic [15:0] addr; logic [15:0] data; } wr_t;

    iss_t iq[$];
    fil_t fq[$];
    wr_t  wq[$];
    bit   dq[$];

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got %0h exp %0h", tag, got, exp);
        end
    endtask

    function automatic logic [15:0] rdfn(input logic [15:0] a);
        return a ^ 16'h5A5A;
    endfunction

    always @(posedge clk) cyc++;

    // Memory: a read issued in cycle c returns in cycle c+2.
    logic        v1 = 1'b0, v2 = 1'b0;
    logic [15:0] r1 = '0, r2 = '0;
    always @(posedge clk) begin
        #1;
        mem_valid = v2;
        mem_rdata = v2 ? r2 : 16'h0000;
        v2 = v1;
        r2 = r1;
        v1 = mem_en && !mem_wr;
        r1 = rdfn(mem_addr);
    end

    iss_t ie;
    fil_t fe;
    wr_t  we;
    bit   de;
    always @(negedge clk) begin
        if (!rst) begin
            if (i_grant && d_grant) chk("grant_excl", 1, 0);
            if (i_done && d_done) chk("done_excl", 1, 0);
            if (mem_en && !mem_wr) begin
                if (iq.size() == 0) chk("iss_unexp", {mem_addr}, 0);
                else begin
                    ie = iq.pop_front();
                    chk("iss_addr", mem_addr, ie.addr);
                    chk("iss_grant", {i_grant, d_grant},
                        ie.d ? 2'b01 : 2'b10);
                    if (ie.idx != 0) chk("iss_gap", cyc - prev_iss, 1);
                    prev_iss = cyc;
                end
            end
            if (mem_en && mem_wr) begin
                if (wq.size() == 0) chk("wr_unexp", mem_addr, 0);
                else begin
                    we = wq.pop_front();
                    chk("wr_addr", mem_addr, we.addr);
                    chk("wr_data", mem_wdata, we.data);
                    chk("wr_grant", d_grant, 1);
                    last_end = cyc;
                end
            end
            if (fill_valid) begin
                if (fq.size() == 0) chk("fill_unexp", fill_data, 0);
                else begin
                    fe = fq.pop_front();
                    chk("fill_data", fill_data, fe.data);
                    chk("fill_word", fill_word, fe.idx);
                    fv_seen++;
                    if (fe.idx == WPB - 1) last_end = cyc;
                end
            end
            if (i_done || d_done) begin
                if (dq.size() == 0) chk("done_unexp", {i_done, d_done}, 0);
                else begin
                    de = dq.pop_front();
                    chk("done_side", {i_done, d_done},
                        de ? 2'b01 : 2'b10);
                    chk("done_lat", cyc - last_end, 1);
                    chk("done_grant", {i_grant, d_grant}, 0);
                end
            end
        end
    end

    task automatic push_exp(input bit d, input bit wr,
                            input logic [15:0] a, input logic [15:0] wd);
        logic [15:0] base;
        iss_t ei;
        fil_t ef;
        wr_t  ew;
        if (wr) begin
            ew.addr = a;
            ew.data = wd;
            wq.push_back(ew);
        end else begin
            base = a & 16'hFFF0;
            for (int k = 0; k < WPB; k++) begin
                ei.addr = base + 16'(2 * k);
                ei.idx = k;
                ei.d = d;
                iq.push_back(ei);
                ef.data = rdfn(ei.addr);
                ef.idx = k;
                fq.push_back(ef);
            end
        end
        dq.push_back(d);
    endtask

    task automatic run_req(input bit d, input bit wr,
                           input logic [15:0] a, input logic [15:0] wd,
                           input int drop_after);
        bit seen = 0;
        if (d) begin
            d_wr = wr; d_addr = a; d_wdata = wd; d_req = 1'b1;
        end else begin
            i_addr = a; i_req = 1'b1;
        end
        for (int n = 0; n < 300 && !seen; n++) begin
            @(negedge clk);
            if (n == drop_after) begin
                if (d) d_req = 1'b0; else i_req = 1'b0;
            end
            if (d ? d_done : i_done) begin
                seen = 1;
                if (d) d_req = 1'b0; else i_req = 1'b0;
            end
        end
        if (!seen) begin
            chk(d ? "timeout_d" : "timeout_i", 0, 1);
            if (d) d_req = 1'b0; else i_req = 1'b0;
        end
    endtask

    task automatic both(input logic [15:0] ia, input logic [15:0] da,
                        input logic [15:0] dw, input bit d_wins);
        if (d_wins) begin
            push_exp(1, 1, da, dw);
            push_exp(0, 0, ia, 0);
        end else begin
            push_exp(0, 0, ia, 0);
            push_exp(1, 1, da, dw);
        end
        fork
            run_req(0, 0, ia, 0, -1);
            run_req(1, 1, da, dw, -1);
        join
        repeat (2) @(negedge clk);
    endtask

    task automatic pulse_rst();
        @(posedge clk); #1;
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        repeat (2) @(negedge clk);
        chk("rst_outs", {mem_en, mem_wr, mem_addr, mem_wdata, fill_data,
            fill_valid, fill_word, i_grant, d_grant, i_done, d_done,
            busy}, 0);
        rst = 1'b0;
        @(negedge clk);
        chk("idle_busy", {busy, i_grant, d_grant}, 0);

        // I-side fill with grant/busy seen one cycle after the request.
        push_exp(0, 0, 16'h1236, 0);
        i_addr = 16'h1236;
        i_req = 1'b1;
        @(negedge clk);
        chk("i_grant_busy", {i_grant, d_grant, busy}, 3'b101);
        run_req(0, 0, 16'h1236, 0, -1);
        @(negedge clk);
        chk("post_busy", busy, 0);

        // Single-word D-side write-through.
        push_exp(1, 1, 16'h0040, 16'hBEEF);
        run_req(1, 1, 16'h0040, 16'hBEEF, -1);
        repeat (2) @(negedge clk);

        // Reset in the middle of a fill.
        push_exp(0, 0, 16'h2000, 0);
        fv_seen = 0;
        i_addr = 16'h2000;
        i_req = 1'b1;
        for (int n = 0; n < 100 && fv_seen < 3; n++) @(negedge clk);
        chk("pre_rst_words", fv_seen >= 3, 1);
        @(posedge clk); #1;
        rst = 1'b1;
        iq.delete(); fq.delete(); wq.delete(); dq.delete();
        #1;
        chk("midrst_outs", {mem_en, mem_wr, mem_addr, mem_wdata, fill_data,
            fill_valid, fill_word, i_grant, d_grant, i_done, d_done,
            busy}, 0);
        i_req = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (6) @(negedge clk);
        push_exp(0, 0, 16'h1236, 0);
        run_req(0, 0, 16'h1236, 0, -1);
        repeat (2) @(negedge clk);

        // Simultaneous requests twice after a fresh reset: D then I.
        pulse_rst();
        both(16'h3000, 16'h0100, 16'h1111, 1);
        both(16'h3010, 16'h0102, 16'h2222, 1);

        // After a lone D grant, round-robin favours I.
        push_exp(1, 1, 16'h0200, 16'h3333);
        run_req(1, 1, 16'h0200, 16'h3333, -1);
        repeat (2) @(negedge clk);
`ifdef MEM_ARB_ROUND_ROBIN_EN
        both(16'h4000, 16'h0204, 16'h4444, 0);
`else
        both(16'h4000, 16'h0204, 16'h4444, 1);
`endif

        // D-side fill with d_req dropped two cycles in.
        push_exp(1, 0, 16'h5555, 0);
        run_req(1, 0, 16'h5555, 0, 2);
        repeat (6) @(negedge clk);

        chk("iq_empty", iq.size(), 0);
        chk("fq_empty", fq.size(), 0);
        chk("wq_empty", wq.size(), 0);
        chk("dq_empty", dq.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
